// File: rtl/ioctl_download_tx.sv
`default_nettype none
// ============================================================================
// Module      : ioctl_download_tx
// Description : Replays a valid/ready byte stream as an ioctl_download
//               transfer, honouring ioctl_wait and a minimum write spacing.
// Revision    : 1.0 - initial release
// ============================================================================
module ioctl_download_tx #(
    parameter int ADDR_W = 25,
    parameter int WR_GAP = 3
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [7:0]        index,
    input  logic [ADDR_W-1:0] length,
    input  logic              src_valid,
    input  logic [7:0]        src_data,
    output logic              src_ready,
    output logic              ioctl_download,
    output logic [7:0]        ioctl_index,
    output logic              ioctl_wr,
    output logic [ADDR_W-1:0] ioctl_addr,
    output logic [7:0]        ioctl_dout,
    input  logic              ioctl_wait,
    output logic              busy,
    output logic              done
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ARM   = 3'd1;
    localparam logic [2:0] S_FETCH = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;

    localparam int              GAP_W    = (WR_GAP > 1) ? $clog2(WR_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(WR_GAP - 1);

    logic [2:0]        state;
    logic [ADDR_W-1:0] len_q;
    logic [ADDR_W-1:0] count;
    logic [GAP_W-1:0]  gap_cnt;

    // Abort masks the handshake so no byte is swallowed by a cancelled transfer.
    assign src_ready = (state == S_FETCH) & ~ioctl_wait & ~abort;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state          <= S_IDLE;
            len_q          <= '0;
            count          <= '0;
            gap_cnt        <= '0;
            ioctl_download <= 1'b0;
            ioctl_index    <= 8'h00;
            ioctl_wr       <= 1'b0;
            ioctl_addr     <= '0;
            ioctl_dout     <= 8'h00;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            ioctl_wr <= 1'b0;
            done     <= 1'b0;
            if (abort && (state != S_IDLE)) begin
                state          <= S_IDLE;
                ioctl_download <= 1'b0;
                busy           <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start && !abort) begin
                            if (length != '0) begin
                                ioctl_index    <= index;
                                len_q          <= length;
                                count          <= '0;
                                ioctl_download <= 1'b1;
                                busy           <= 1'b1;
                                state          <= S_ARM;
                            end else begin
                                done <= 1'b1;
                            end
                        end
                    end
                    S_ARM: begin
                        state <= S_FETCH;
                    end
                    S_FETCH: begin
                        if (src_valid && src_ready) begin
                            ioctl_dout <= src_data;
                            ioctl_addr <= count;
                            ioctl_wr   <= 1'b1;
                            state      <= S_WRITE;
                        end
                    end
                    S_WRITE: begin
                        count   <= count + ADDR_W'(1);
                        gap_cnt <= '0;
                        state   <= S_GAP;
                    end
                    S_GAP: begin
                        // Counter saturates at the last gap cycle; wait then stalls the exit.
                        if (gap_cnt != GAP_LAST) begin
                            gap_cnt <= gap_cnt + GAP_W'(1);
                        end else if (!ioctl_wait) begin
                            if (count == len_q) begin
                                ioctl_download <= 1'b0;
                                busy           <= 1'b0;
                                done           <= 1'b1;
                                state          <= S_IDLE;
                            end else begin
                                state <= S_FETCH;
                            end
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ioctl_download_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_ioctl_download_tx
// Description : Scoreboard bench for ioctl_download_tx with random bytes,
//               directed timing cases and randomised source/wait traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ioctl_download_tx;

    localparam int G   = 3;
    localparam int PER = G + 2;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [7:0]  index = 8'h00;
    logic [24:0] length = '0;
    logic        src_valid = 1'b0;
    logic [7:0]  src_data = 8'h00;
    logic        src_ready;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        ioctl_wait = 1'b0;
    logic        busy;
    logic        done;

    ioctl_download_tx #(.ADDR_W(25), .WR_GAP(G)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .start(start), .abort(abort),
        .index(index), .length(length), .src_valid(src_valid), .src_data(src_data),
        .src_ready(src_ready), .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
        .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .ioctl_wait(ioctl_wait), .busy(busy), .done(done)
    );

    always #5 clk_sys = ~clk_sys;

    int cyc = 0;
    always @(posedge clk_sys) cyc++;

    typedef struct {
        int addr;
        int data;
    } wr_t;

    int  errors = 0;
    int  checks = 0;
    wr_t exp_q[$];
    int  stb_q[$];
    int  done_cnt = 0;
    int  done_cyc = -1;
    int  dl_rise = -1;
    int  rdy_rise = -1;
    logic dl_prev = 1'b0;
    logic rdy_prev = 1'b0;

    // source / wait stimulus controls
    logic [7:0] src_mem [0:255];
    int  src_len = 0;
    int  xfer_id = 0;
    bit  src_hold = 1'b0;
    bit  src_rand = 1'b0;
    bit  wait_rand = 1'b0;
    bit  wait_force = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every strobe and logs event cycles.
    always @(negedge clk_sys) begin
        wr_t e;
        if (reset_n) begin
            if (ioctl_wr) begin
                stb_q.push_back(cyc);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe: got addr %0d data %0d expected no write",
                             ioctl_addr, ioctl_dout);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", ioctl_addr, e.addr);
                    chk("wr_data", ioctl_dout, e.data);
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                chk("done_download_low", ioctl_download, 0);
                chk("done_busy_low", busy, 0);
            end
            if (ioctl_download && !dl_prev && dl_rise < 0) dl_rise = cyc;
            if (src_ready && !rdy_prev && rdy_rise < 0) rdy_rise = cyc;
        end
        dl_prev  = ioctl_download;
        rdy_prev = src_ready;
    end

    // Source and wait driver: updates 2 time units after each rising edge.
    initial begin
        int  idx = 0;
        int  seen = 0;
        bit  fire;
        forever begin
            @(negedge clk_sys);
            fire = src_valid && src_ready;
            @(posedge clk_sys);
            #2;
            if (xfer_id != seen) begin
                seen = xfer_id;
                idx  = 0;
            end else if (fire) begin
                idx++;
            end
            src_valid  = !src_hold && (idx < src_len) && (!src_rand || $urandom_range(3) != 0);
            src_data   = (idx < src_len) ? src_mem[idx] : 8'h00;
            ioctl_wait = wait_rand ? ($urandom_range(4) == 0) : wait_force;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    task automatic start_xfer(input int len, output int s);
        wr_t e;
        for (int i = 0; i < len; i++) begin
            src_mem[i] = 8'($urandom);
            e.addr = i;
            e.data = int'(src_mem[i]);
            exp_q.push_back(e);
        end
        src_len = len;
        stb_q.delete();
        dl_rise  = -1;
        rdy_rise = -1;
        xfer_id++;
        index  = 8'($urandom);
        length = 25'(len);
        start  = 1'b1;
        s = cyc;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int budget);
        int n = 0;
        while (done_cnt == d0 && n < budget) begin
            tick(1);
            n++;
        end
        if (done_cnt == d0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done within %0d cycles expected one", budget);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int s, d0, t2, lat_idx, len;

        // reset state
        tick(3);
        #2;
        chk("rst_download", ioctl_download, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_wr", ioctl_wr, 0);
        chk("rst_addr", ioctl_addr, 0);
        chk("rst_src_ready", src_ready, 0);
        reset_n = 1'b1;
        tick(2);

        // basic 3-byte transfer, exact cycle timing
        d0 = done_cnt;
        start_xfer(3, s);
        lat_idx = int'(index);
        wait_done(d0, 300);
        chk("t1_download_rise", dl_rise, s + 1);
        chk("t1_ready_rise", rdy_rise, s + 2);
        chk("t1_strobes", stb_q.size(), 3);
        for (int k = 0; k < 3 && k < stb_q.size(); k++)
            chk("t1_strobe_cycle", stb_q[k], s + 3 + k * PER);
        chk("t1_done_cycle", done_cyc, s + 3 + 2 * PER + G + 1);
        chk("t1_addr_held", ioctl_addr, 2);
        chk("t1_index", ioctl_index, lat_idx);
        chk("t1_scoreboard_empty", exp_q.size(), 0);

        // zero-length start is a no-op with an immediate done
        tick(2);
        d0 = done_cnt;
        start_xfer(0, s);
        wait_done(d0, 20);
        chk("t0_done_cycle", done_cyc, s + 1);
        tick(5);
        chk("t0_strobes", stb_q.size(), 0);
        chk("t0_no_download", dl_rise, -1);

        // wait held through the second strobe and six GAP exit decisions
        d0 = done_cnt;
        start_xfer(3, s);
        t2 = s + 3 + PER;
        while (cyc < t2) tick(1);
        wait_force = 1'b1;
        tick(G + 6);
        wait_force = 1'b0;
        wait_done(d0, 300);
        chk("stall_strobes", stb_q.size(), 3);
        if (stb_q.size() == 3) begin
            chk("stall_second_strobe", stb_q[1], t2);
            chk("stall_third_strobe", stb_q[2], s + 3 + 2 * PER + 6);
        end
        chk("stall_done_cycle", done_cyc, s + 3 + 2 * PER + G + 1 + 6);

        // src_valid low for 4 FETCH cycles mid-stream
        tick(2);
        d0 = done_cnt;
        start_xfer(4, s);
        while (cyc < s + 3 + G + 1) tick(1);
        src_hold = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #2;
            chk("gap_src_ready_high", src_ready, 1);
            chk("gap_no_strobe", ioctl_wr, 0);
            tick(1);
        end
        src_hold = 1'b0;
        wait_done(d0, 300);
        chk("gap_strobes", stb_q.size(), 4);
        if (stb_q.size() >= 2) chk("gap_second_strobe", stb_q[1], s + 3 + PER + 4);
        chk("gap_last_addr", ioctl_addr, 3);

        // abort in GAP after the first of four bytes
        tick(2);
        d0 = done_cnt;
        start_xfer(4, s);
        while (cyc < s + 5) tick(1);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        chk("abort_download_low", ioctl_download, 0);
        chk("abort_busy_low", busy, 0);
        tick(30);
        chk("abort_no_done", done_cnt, d0);
        chk("abort_strobes", stb_q.size(), 1);
        chk("abort_remaining", exp_q.size(), 3);
        exp_q.delete();
        d0 = done_cnt;
        start_xfer(2, s);
        wait_done(d0, 300);
        chk("restart_strobes", stb_q.size(), 2);

        // start together with abort in IDLE is ignored
        tick(2);
        d0 = done_cnt;
        length = 25'd2;
        start = 1'b1;
        abort = 1'b1;
        tick(1);
        start = 1'b0;
        abort = 1'b0;
        tick(6);
        chk("abort_start_download", ioctl_download, 0);
        chk("abort_start_done", done_cnt, d0);

        // asynchronous reset mid-transfer
        d0 = done_cnt;
        start_xfer(4, s);
        while (cyc < s + 9) tick(1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_download", ioctl_download, 0);
        chk("arst_busy", busy, 0);
        chk("arst_addr", ioctl_addr, 0);
        chk("arst_dout", ioctl_dout, 0);
        chk("arst_index", ioctl_index, 0);
        chk("arst_src_ready", src_ready, 0);
        tick(2);
        reset_n = 1'b1;
        exp_q.delete();
        tick(2);
        chk("arst_idle_busy", busy, 0);

        // start pulses while busy are ignored
        d0 = done_cnt;
        start_xfer(3, s);
        lat_idx = int'(index);
        tick(4);
        index  = ~index;
        length = 25'd7;
        start  = 1'b1;
        tick(1);
        start = 1'b0;
        wait_done(d0, 300);
        tick(20);
        chk("busy_start_strobes", stb_q.size(), 3);
        chk("busy_start_done", done_cnt, d0 + 1);
        chk("busy_start_index", ioctl_index, lat_idx);
        chk("busy_start_idle", ioctl_download, 0);

        // randomised source validity and consumer back-pressure
        src_rand  = 1'b1;
        wait_rand = 1'b1;
        for (int r = 0; r < 8; r++) begin
            len = $urandom_range(1, 8);
            d0 = done_cnt;
            start_xfer(len, s);
            wait_done(d0, 600);
            chk("rnd_strobes", stb_q.size(), len);
            chk("rnd_last_addr", ioctl_addr, len - 1);
            chk("rnd_scoreboard_empty", exp_q.size(), 0);
            tick($urandom_range(1, 4));
        end
        src_rand  = 1'b0;
        wait_rand = 1'b0;
        tick(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
